// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signals between a single-transfer master and its slave.
interface ahb_lite_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output sel,
        output addr,
        output trans,
        output write,
        output size,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  sel,
        input  addr,
        input  trans,
        input  write,
        input  size,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into pipelined
// NONSEQ single transfers, honours HREADY wait states and returns one response per transfer.
// Only DATA_W = 32 is supported; write data is driven as-is with no lane steering.
module ahb_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response / status
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cmd_err,
    output logic              busy,
    // AHB-Lite bus
    ahb_lite_master_if.master bus
);

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransNonseq = 2'b10
    } trans_e;

    // Address-phase stage: these registers are the bus address/control outputs.
    trans_e            ap_trans_q, ap_trans_d;
    logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
    logic              ap_write_q, ap_write_d;
    logic [2:0]        ap_size_q, ap_size_d;
    // Write data rides with the address phase until it is driven in the data phase.
    logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;

    // Data-phase stage. Size is not kept here: without lane steering nothing in the
    // data phase depends on it.
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Response and error pulses.
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              cmd_err_q, cmd_err_d;

    logic              ap_nonseq;
    logic              cmd_accept;
    logic              cmd_legal;

    assign cmd_ready  = bus.ready & ~reset;
    assign cmd_accept = cmd_valid & cmd_ready;
    assign ap_nonseq  = (ap_trans_q == TransNonseq);

    // Legality: size must be byte/halfword/word and the address naturally aligned.
    always_comb begin
        cmd_legal = 1'b0;
        unique case (cmd_size)
            3'd0:    cmd_legal = 1'b1;
            3'd1:    cmd_legal = ~cmd_addr[0];
            3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // Pipeline advance: everything holds while HREADY is low.
    always_comb begin
        ap_trans_d  = ap_trans_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        cmd_err_d   = 1'b0;

        if (bus.ready) begin
            // Data phase completes: report it next cycle.
            if (dp_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_write_d = dp_write_q;
                rsp_rdata_d = dp_write_q ? '0 : bus.rdata;
            end

            // Address phase moves into the data phase.
            dp_valid_d = ap_nonseq;
            if (ap_nonseq) begin
                dp_write_d = ap_write_q;
                if (ap_write_q) begin
                    wdata_d = ap_wdata_q;
                end
            end

            // New address phase: an accepted legal command, otherwise IDLE.
            // Address/control hold their last values while IDLE.
            ap_trans_d = TransIdle;
            if (cmd_accept) begin
                if (cmd_legal) begin
                    ap_trans_d = TransNonseq;
                    ap_addr_d  = cmd_addr;
                    ap_write_d = cmd_write;
                    ap_size_d  = cmd_size;
                    ap_wdata_d = cmd_wdata;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ap_trans_q  <= TransIdle;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= '0;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            ap_trans_q  <= ap_trans_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.trans = ap_trans_q;
    assign bus.sel   = ap_nonseq;
    assign bus.addr  = ap_addr_q;
    assign bus.write = ap_write_q;
    assign bus.size  = ap_size_q;
    assign bus.wdata = wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = ap_nonseq | dp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed vector table, hand-written
// multi-cycle sequences and random traffic against a transaction-queue model.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        cmd_err;
    logic        busy;
    logic        ready_in;
    logic [31:0] rdata_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.ready = ready_in;
    assign bus.rdata = rdata_in;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .bus       (bus)
    );

    // ---------------------------------------------------------------- reference model
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       ap_q[$];
    xfer_t       dp_q[$];
    logic        exp_rsp_valid = 1'b0;
    logic        exp_rsp_write = 1'b0;
    logic [31:0] exp_rsp_rdata = '0;
    logic        exp_err       = 1'b0;
    logic [31:0] exp_wdata     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] addr, input logic [2:0] size);
        int unsigned bytes;
        if (size > 3'd2) return 1'b0;
        bytes = 1 << size;
        return (addr % bytes) == 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        xfer_t x;
        if (reset) begin
            ap_q.delete();
            dp_q.delete();
            exp_rsp_valid = 1'b0;
            exp_rsp_write = 1'b0;
            exp_rsp_rdata = '0;
            exp_err       = 1'b0;
            exp_wdata     = '0;
        end else begin
            exp_rsp_valid = 1'b0;
            exp_err       = 1'b0;
            if (ready_in) begin
                if (dp_q.size() != 0) begin
                    x = dp_q.pop_front();
                    exp_rsp_valid = 1'b1;
                    exp_rsp_write = x.write;
                    exp_rsp_rdata = x.write ? 32'h0 : rdata_in;
                end
                if (ap_q.size() != 0) begin
                    x = ap_q.pop_front();
                    dp_q.push_back(x);
                    if (x.write) exp_wdata = x.wdata;
                end
                if (cmd_valid) begin
                    if (legal(cmd_addr, cmd_size)) begin
                        x.addr  = cmd_addr;
                        x.write = cmd_write;
                        x.size  = cmd_size;
                        x.wdata = cmd_wdata;
                        ap_q.push_back(x);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        logic ap_busy;
        ap_busy = (ap_q.size() != 0);
        chk("m.trans", {30'h0, bus.trans}, ap_busy ? 32'h2 : 32'h0);
        chk("m.sel", bus.sel, ap_busy);
        if (ap_busy) begin
            chk("m.addr", bus.addr, ap_q[0].addr);
            chk("m.write", bus.write, ap_q[0].write);
            chk("m.size", {29'h0, bus.size}, {29'h0, ap_q[0].size});
        end
        chk("m.wdata", bus.wdata, exp_wdata);
        chk("m.busy", busy, ap_busy | (dp_q.size() != 0));
        chk("m.rsp_valid", rsp_valid, exp_rsp_valid);
        chk("m.rsp_write", rsp_write, exp_rsp_write);
        chk("m.rsp_rdata", rsp_rdata, exp_rsp_rdata);
        chk("m.cmd_err", cmd_err, exp_err);
    endtask

    // One clock: called at posedge+1 with inputs applied, returns at next posedge+1.
    task automatic cycle();
        #1;
        chk("cmd_ready", cmd_ready, ready_in & ~reset);
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_cmd(input logic v, input logic [31:0] a, input logic w,
                           input logic [2:0] s, input logic [31:0] wd);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_write = w;
        cmd_size  = s;
        cmd_wdata = wd;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct packed {
        logic        rst;
        logic        cv;
        logic [31:0] ca;
        logic        cw;
        logic [2:0]  cs;
        logic [31:0] cwd;
        logic        rdy;
        logic [31:0] rd;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_rsp;
        logic        e_rspw;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic cv, input logic [31:0] ca, input logic cw,
        input logic [2:0] cs, input logic [31:0] cwd, input logic rdy, input logic [31:0] rd,
        input logic [1:0] e_trans, input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic e_rsp, input logic e_rspw, input logic [31:0] e_rdata,
        input logic e_err, input logic e_busy);
        vec_t v;
        v = {rst, cv, ca, cw, cs, cwd, rdy, rd, e_trans, e_addr, e_wdata,
             e_rsp, e_rspw, e_rdata, e_err, e_busy};
        return v;
    endfunction

    localparam logic [31:0] WD = 32'hA5A5_00FF;

    initial begin
        vec_t        vecs[16];
        logic [1:0]  seq_trans[6];
        logic        seq_rsp[6];
        logic        seq_rspw[6];
        logic [31:0] seq_addr[6];
        logic        seq_w[6];
        logic [31:0] seq_rdata[6];
        logic        pend;

        reset = 1'b1;
        ready_in = 1'b1;
        rdata_in = '0;
        set_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        @(negedge clk);
        @(posedge clk);
        #1;

        //            rst cv  addr           w   sz    wdata rdy rdata
        //            trans addr         wdata rsp rspw rdata      err busy
        vecs[0]  = mk(1, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            0,  0, 0, 0,          0, 0);
        vecs[1]  = mk(0, 1, 32'h5000_0004, 1, 2, WD, 1, 0,
                      2, 32'h5000_0004, 0,  0, 0, 0,          0, 1);
        vecs[2]  = mk(0, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            WD, 0, 0, 0,          0, 1);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            WD, 1, 1, 0,          0, 0);
        vecs[4]  = mk(0, 1, 32'h5000_0000, 0, 2, 0,  1, 0,
                      2, 32'h5000_0000, WD, 0, 1, 0,          0, 1);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,  1, 32'h0,
                      0, 0,            WD, 0, 1, 0,          0, 1);
        vecs[6]  = mk(0, 0, 0,            0, 0, 0,  1, 32'h0000_1234,
                      0, 0,            WD, 1, 0, 32'h1234,   0, 0);
        vecs[7]  = mk(0, 1, 32'h2,        0, 2, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   1, 0);
        vecs[8]  = mk(0, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   0, 0);
        vecs[9]  = mk(0, 1, 32'h0,        1, 3, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   1, 0);
        vecs[10] = mk(0, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   0, 0);
        vecs[11] = mk(0, 1, 32'h3,        0, 1, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   1, 0);
        vecs[12] = mk(0, 0, 0,            0, 0, 0,  1, 0,
                      0, 0,            WD, 0, 0, 32'h1234,   0, 0);
        vecs[13] = mk(0, 1, 32'h3,        0, 0, 0,  1, 32'h55,
                      2, 32'h3,        WD, 0, 0, 32'h1234,   0, 1);
        vecs[14] = mk(0, 0, 0,            0, 0, 0,  1, 32'h77,
                      0, 0,            WD, 0, 0, 32'h1234,   0, 1);
        vecs[15] = mk(0, 0, 0,            0, 0, 0,  1, 32'hAB,
                      0, 0,            WD, 1, 0, 32'hAB,     0, 0);

        for (int i = 0; i < 16; i++) begin
            reset    = vecs[i].rst;
            ready_in = vecs[i].rdy;
            rdata_in = vecs[i].rd;
            set_cmd(vecs[i].cv, vecs[i].ca, vecs[i].cw, vecs[i].cs, vecs[i].cwd);
            cycle();
            chk($sformatf("v%0d.trans", i), {30'h0, bus.trans}, {30'h0, vecs[i].e_trans});
            chk($sformatf("v%0d.sel", i), bus.sel, vecs[i].e_trans == 2'b10);
            if (vecs[i].e_trans == 2'b10)
                chk($sformatf("v%0d.addr", i), bus.addr, vecs[i].e_addr);
            if (i == 0) begin
                chk("v0.addr", bus.addr, 32'h0);
                chk("v0.write", bus.write, 1'b0);
                chk("v0.size", {29'h0, bus.size}, 32'h0);
            end
            chk($sformatf("v%0d.wdata", i), bus.wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d.rsp_valid", i), rsp_valid, vecs[i].e_rsp);
            chk($sformatf("v%0d.rsp_write", i), rsp_write, vecs[i].e_rspw);
            chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d.cmd_err", i), cmd_err, vecs[i].e_err);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
        end

        // Back-to-back W 0x0, R 0x4, W 0x8 with cmd_valid held.
        seq_addr  = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0};
        seq_w     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_rdata = '{32'h0, 32'h0, 32'h0, 32'hCAFE_0004, 32'h0, 32'h0};
        seq_trans = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        seq_rsp   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        seq_rspw  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            set_cmd(i < 3, seq_addr[i], seq_w[i], 3'd2, 32'h1111_0000 + i);
            rdata_in = seq_rdata[i];
            cycle();
            chk($sformatf("b2b%0d.trans", i), {30'h0, bus.trans}, {30'h0, seq_trans[i]});
            chk($sformatf("b2b%0d.rsp_valid", i), rsp_valid, seq_rsp[i]);
            if (seq_rsp[i]) chk($sformatf("b2b%0d.rsp_write", i), rsp_write, seq_rspw[i]);
        end
        chk("b2b.read_rdata_seen", exp_rsp_rdata, 32'h0);  // last response was a write

        // Two back-to-back reads with two wait states during the first data phase.
        set_cmd(1'b1, 32'h10, 1'b0, 3'd2, '0);
        cycle();
        set_cmd(1'b1, 32'h14, 1'b0, 3'd2, '0);
        cycle();
        chk("ws.addr0", bus.addr, 32'h14);
        set_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        for (int i = 0; i < 2; i++) begin
            ready_in = 1'b0;
            rdata_in = 32'hDEAD_0000 + i;
            #1;
            chk($sformatf("ws%0d.cmd_ready", i), cmd_ready, 1'b0);
            cycle();
            chk($sformatf("ws%0d.addr", i), bus.addr, 32'h14);
            chk($sformatf("ws%0d.trans", i), {30'h0, bus.trans}, 32'h2);
            chk($sformatf("ws%0d.rsp_valid", i), rsp_valid, 1'b0);
        end
        ready_in = 1'b1;
        rdata_in = 32'hD000_0010;
        cycle();
        chk("ws.rsp1_valid", rsp_valid, 1'b1);
        chk("ws.rsp1_rdata", rsp_rdata, 32'hD000_0010);
        rdata_in = 32'hD000_0014;
        cycle();
        chk("ws.rsp2_valid", rsp_valid, 1'b1);
        chk("ws.rsp2_rdata", rsp_rdata, 32'hD000_0014);
        cycle();
        chk("ws.idle_busy", busy, 1'b0);

        // Reset asserted during the data phase of a read.
        set_cmd(1'b1, 32'h20, 1'b0, 3'd2, '0);
        cycle();
        set_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        cycle();
        chk("rst.in_dp_busy", busy, 1'b1);
        reset = 1'b1;
        rdata_in = 32'h0000_0999;
        cycle();
        chk("rst.trans", {30'h0, bus.trans}, 32'h0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("rst.after%0d_rsp", i), rsp_valid, 1'b0);
            chk($sformatf("rst.after%0d_err", i), cmd_err, 1'b0);
        end

        // Random traffic checked by the model; commands are held until accepted.
        pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend) begin
                set_cmd($urandom_range(0, 99) < 60, $urandom & 32'h0000_FFFF,
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom);
            end
            ready_in = $urandom_range(0, 99) < 75;
            rdata_in = $urandom;
            reset    = $urandom_range(0, 199) == 0;
            pend     = cmd_valid & ~(ready_in & ~reset);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
